// File: rtl/clk_div_ctrl.sv
// Run-time programmable clock-divider controller: modulo-N period counter with
// boundary-aligned divisor changes and graceful start/stop.
module clk_div_ctrl #(
    parameter int unsigned CW        = 4,
    parameter int unsigned DEFAULT_N = 5
) (
    input  logic          clk_in,
    input  logic          rst,
    input  logic          en,
    input  logic          cfg_valid,
    input  logic [CW-1:0] cfg_n,
    output logic          cfg_ready,
    output logic          cfg_err,
    output logic [CW-1:0] cur_n,
    output logic [CW-1:0] count,
    output logic          running,
    output logic          tick,
    output logic          div_out
);

    typedef enum logic [0:0] {StStop, StRun} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] cur_n_q, cur_n_d;
    logic [CW-1:0] pend_n_q, pend_n_d;
    logic          pending_q, pending_d;
    logic          cfg_err_q, cfg_err_d;

    logic          accept;
    logic          wrap;
    logic [CW:0]   last_cnt;
    logic [CW:0]   half_n;

    // Extra bit keeps N = 2^CW-1 from overflowing in the compares.
    assign last_cnt = {1'b0, cur_n_q} - (CW+1)'(1);
    assign half_n   = ({1'b0, cur_n_q} + (CW+1)'(1)) >> 1;
    assign wrap     = (state_q == StRun) && ({1'b0, count_q} == last_cnt);
    assign accept   = cfg_valid && !pending_q;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        cur_n_d   = cur_n_q;
        pend_n_d  = pend_n_q;
        pending_d = pending_q;
        cfg_err_d = 1'b0;

        unique case (state_q)
            StStop: begin
                count_d = '0;
                if (en) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (wrap) begin
                    count_d = '0;
                    if (!en) begin
                        state_d = StStop;
                    end
                    if (pending_q) begin
                        cur_n_d   = pend_n_q;
                        pending_d = 1'b0;
                    end
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
            default: begin
                state_d = StStop;
                count_d = '0;
            end
        endcase

        if (accept) begin
            if (cfg_n < CW'(2)) begin
                cfg_err_d = 1'b1;
            end else if (state_q == StStop) begin
                cur_n_d = cfg_n;
            end else begin
                pend_n_d  = cfg_n;
                pending_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q   <= StStop;
            count_q   <= '0;
            cur_n_q   <= CW'(DEFAULT_N);
            pend_n_q  <= '0;
            pending_q <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            cur_n_q   <= cur_n_d;
            pend_n_q  <= pend_n_d;
            pending_q <= pending_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign running   = (state_q == StRun);
    assign cfg_ready = !pending_q;
    assign cfg_err   = cfg_err_q;
    assign cur_n     = cur_n_q;
    assign count     = count_q;
    assign tick      = running && (count_q == '0);
    assign div_out   = running && ({1'b0, count_q} < half_n);

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scoreboard bench for clk_div_ctrl: a behavioural model queues expected outputs per cycle,
// which are popped and compared after each clock edge.
module tb_clk_div_ctrl;

    logic       clk_in = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [3:0] cfg_n = '0;
    logic       cfg_ready, cfg_err, running, tick, div_out;
    logic [3:0] cur_n, count;

    clk_div_ctrl #(.CW(4), .DEFAULT_N(5)) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_n     (cfg_n),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .cur_n     (cur_n),
        .count     (count),
        .running   (running),
        .tick      (tick),
        .div_out   (div_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic       tick;
        logic       div;
        logic       run;
        logic       rdy;
        logic       err;
        logic [3:0] cnt;
        logic [3:0] n;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   tick_cnt = 0;

    // Behavioural reference state
    int m_run = 0, m_cnt = 0, m_n = 5, m_pend = 0, m_pn = 0, m_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit e, input bit v, input int n);
        int  nrun, ncnt, nn, npend, npn;
        bit  acc;
        if (r) begin
            m_run = 0; m_cnt = 0; m_n = 5; m_pend = 0; m_pn = 0; m_err = 0;
            return;
        end
        nrun = m_run; ncnt = m_cnt; nn = m_n; npend = m_pend; npn = m_pn;
        acc = v && (m_pend == 0);
        if (m_run == 0) begin
            ncnt = 0;
            nrun = e;
        end else if (m_cnt + 1 == m_n) begin
            ncnt = 0;
            nrun = e;
            if (m_pend != 0) begin
                nn = m_pn;
                npend = 0;
            end
        end else begin
            ncnt = m_cnt + 1;
        end
        m_err = 0;
        if (acc) begin
            if (n < 2) m_err = 1;
            else if (m_run == 0) nn = n;
            else begin
                npn = n;
                npend = 1;
            end
        end
        m_run = nrun; m_cnt = ncnt; m_n = nn; m_pend = npend; m_pn = npn;
    endtask

    // Drive one cycle of stimulus, queue the expected result, then compare after the edge.
    task automatic cycle(input bit r, input bit e, input bit v, input int n);
        exp_t x, g;
        rst = r; en = e; cfg_valid = v; cfg_n = 4'(n);
        model_step(r, e, v, n);
        x.tick = (m_run != 0) && (m_cnt == 0);
        x.div  = (m_run != 0) && (2 * m_cnt < m_n);
        x.run  = (m_run != 0);
        x.rdy  = (m_pend == 0);
        x.err  = (m_err != 0);
        x.cnt  = 4'(m_cnt);
        x.n    = 4'(m_n);
        exp_q.push_back(x);
        @(posedge clk_in);
        #1;
        g = exp_q.pop_front();
        check("tick", 32'(tick), 32'(g.tick));
        check("div_out", 32'(div_out), 32'(g.div));
        check("running", 32'(running), 32'(g.run));
        check("cfg_ready", 32'(cfg_ready), 32'(g.rdy));
        check("cfg_err", 32'(cfg_err), 32'(g.err));
        check("count", 32'(count), 32'(g.cnt));
        check("cur_n", 32'(cur_n), 32'(g.n));
        if (tick) tick_cnt++;
    endtask

    task automatic run_to(input int c, input bit e);
        for (int i = 0; i < 20 && m_cnt != c; i++) cycle(0, e, 0, 0);
    endtask

    initial begin
        #1;
        // Reset and default N=5 run
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        check("reset_cur_n", 32'(cur_n), 32'd5);
        check("reset_ready", 32'(cfg_ready), 32'd1);
        for (int i = 0; i < 12; i++) cycle(0, 1, 0, 0);

        // Change to N=3 mid-period
        run_to(1, 1);
        cycle(0, 1, 1, 3);
        for (int i = 0; i < 12; i++) cycle(0, 1, 0, 0);

        // Illegal divisors while running
        cycle(0, 1, 1, 1);
        cycle(0, 1, 0, 0);
        cycle(0, 1, 1, 0);
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0);

        // Back to N=5, held offer of 4 overlaps the wrap that applies 5
        cycle(0, 1, 1, 5);
        for (int i = 0; i < 5; i++) cycle(0, 1, 1, 4);
        for (int i = 0; i < 10; i++) cycle(0, 1, 0, 0);
        cycle(0, 1, 1, 5);
        for (int i = 0; i < 10; i++) cycle(0, 1, 0, 0);

        // Drop en at count 2, stop at the wrap; illegal offers while stopped
        run_to(2, 1);
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0);
        check("stopped", 32'(running), 32'd0);
        cycle(0, 0, 1, 0);
        cycle(0, 0, 1, 1);
        cycle(0, 0, 0, 0);
        cycle(0, 1, 0, 0);
        check("restart_tick", 32'(tick), 32'd1);
        for (int i = 0; i < 6; i++) cycle(0, 1, 0, 0);

        // Pending divisor applied on the stopping wrap
        run_to(1, 1);
        cycle(0, 1, 1, 4);
        for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0);
        check("stop_applies_pend", 32'(cur_n), 32'd4);

        // N=2 boundary: 100 periods
        cycle(1, 0, 0, 0);
        cycle(0, 0, 1, 2);
        tick_cnt = 0;
        for (int i = 0; i < 200; i++) cycle(0, 1, 0, 0);
        check("n2_ticks", 32'(tick_cnt), 32'd100);

        // N=15 boundary: 100 periods
        cycle(1, 0, 0, 0);
        cycle(0, 0, 1, 15);
        tick_cnt = 0;
        for (int i = 0; i < 1500; i++) cycle(0, 1, 0, 0);
        check("n15_ticks", 32'(tick_cnt), 32'd100);

        // Reset with 7 pending at count 3
        cycle(1, 0, 0, 0);
        cycle(0, 1, 0, 0);
        run_to(1, 1);
        cycle(0, 1, 1, 7);
        run_to(3, 1);
        cycle(1, 1, 0, 0);
        check("rst_cur_n", 32'(cur_n), 32'd5);
        check("rst_ready", 32'(cfg_ready), 32'd1);
        for (int i = 0; i < 15; i++) cycle(0, 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
